btb_update_ctrl: RTL

- Sequences all writes into the 512-set, 2-way branch target buffer array.
- On reset it sweeps every set to zero, then drains queued branch-resolution updates from execute.
- Each update is a read-modify-write (RMW) of one 107-bit set: hit update, LRU allocation or drop.
- Shares the single array port with fetch lookups; fetch always wins.

---
 rtl/btb_update_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer: reset sweep, then FIFO-fed read-modify-write updates
module btb_update_ctrl #(
    parameter int QDEPTH = 4,
    parameter int NSETS  = 512
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [31:0]                upd_pc,
    input  logic [31:0]                upd_target,
    input  logic                       upd_taken,
    input  logic                       lookup_active,
    output logic [$clog2(NSETS)-1:0]   arr_index,
    output logic                       arr_rd_en,
    input  logic [106:0]               arr_rd_data,
    output logic                       arr_wr_en,
    output logic [106:0]               arr_wr_data,
    output logic                       init_done,
    output logic                       busy
);
    localparam int IW = $clog2(NSETS);
    localparam int AW = $clog2(QDEPTH);
    localparam int TW = 21;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] cnt;

    // Queue entries keep only addr[31:2]; the low bits never reach the array.
    logic [29:0]   fifo_pc    [QDEPTH];
    logic [29:0]   fifo_tgt   [QDEPTH];
    logic          fifo_taken [QDEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [29:0]   head_pc;

    logic [29:0]   w_pc, w_tgt;
    logic          w_taken;
    logic [106:0]  set_q, new_set;
    logic          hit1, hit2, drop;
    logic [TW-1:0] w_tag;

    logic          unused_bits;
    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign upd_ready = !full;
    assign push      = upd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty && !lookup_active;
    assign head_pc   = fifo_pc[rd_ptr[AW-1:0]];
    assign busy      = !empty || (state != S_IDLE);
    assign w_tag     = w_pc[29 -: TW];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_pc[wr_ptr[AW-1:0]]    <= upd_pc[31:2];
            fifo_tgt[wr_ptr[AW-1:0]]   <= upd_target[31:2];
            fifo_taken[wr_ptr[AW-1:0]] <= upd_taken;
        end
    end

    // Way1 is checked first so a corrupted double-hit set updates way1.
    always_comb begin
        new_set = arr_rd_data;
        hit1    = arr_rd_data[105] && (arr_rd_data[104:84] == w_tag);
        hit2    = arr_rd_data[52]  && (arr_rd_data[51:31]  == w_tag);
        drop    = 1'b0;
        if (hit1) begin
            new_set[83:54] = w_tgt;
            new_set[53]    = w_taken;
            new_set[106]   = 1'b0;
        end else if (hit2) begin
            new_set[30:1]  = w_tgt;
            new_set[0]     = w_taken;
            new_set[106]   = 1'b1;
        end else if (w_taken) begin
            if (arr_rd_data[106]) begin
                new_set[105]    = 1'b1;
                new_set[104:84] = w_tag;
                new_set[83:54]  = w_tgt;
                new_set[53]     = 1'b1;
                new_set[106]    = 1'b0;
            end else begin
                new_set[52]     = 1'b1;
                new_set[51:31]  = w_tag;
                new_set[30:1]   = w_tgt;
                new_set[0]      = 1'b1;
                new_set[106]    = 1'b1;
            end
        end else begin
            drop = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            w_pc      <= '0;
            w_tgt     <= '0;
            w_taken   <= 1'b0;
            set_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IW'(NSETS - 1)) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (pop) begin
                        w_pc    <= head_pc;
                        w_tgt   <= fifo_tgt[rd_ptr[AW-1:0]];
                        w_taken <= fifo_taken[rd_ptr[AW-1:0]];
                        state   <= S_CAP;
                    end
                end
                S_CAP: begin
                    set_q <= new_set;
                    state <= drop ? S_IDLE : S_WR;
                end
                default: begin
                    if (!lookup_active) state <= S_IDLE;
                end
            endcase
        end
    end

    // The sweep strobe is qualified by RESET so nothing is written while reset is held.
    always_comb begin
        arr_rd_en   = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_data = '0;
        arr_index   = cnt;
        case (state)
            S_INIT: begin
                arr_wr_en = RESET;
                arr_index = cnt;
            end
            S_IDLE: begin
                arr_rd_en = pop;
                arr_index = head_pc[IW-1:0];
            end
            S_CAP: begin
                arr_index = w_pc[IW-1:0];
            end
            default: begin
                arr_wr_en   = !lookup_active;
                arr_wr_data = set_q;
                arr_index   = w_pc[IW-1:0];
            end
        endcase
    end
endmodule
